// File: rtl/image_copy_dma.sv
// image_copy_dma: word block copier that masters the data memory manager port while busy
module image_copy_dma #(
    parameter int LEN_W = 18
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start_i,
    input  logic             abort_i,
    input  logic [31:0]      src_base_i,
    input  logic [31:0]      dst_base_i,
    input  logic [LEN_W-1:0] length_i,
    input  logic [31:0]      mem_data_i,
    output logic [31:0]      mem_address_o,
    output logic [31:0]      mem_data_o,
    output logic             mem_wren_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             aborted_o,
    output logic [LEN_W-1:0] count_o
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    state_t state;
    logic [31:0] src, dst, data;
    logic [LEN_W-1:0] len, idx;
    logic last;
    assign last = idx == len - LEN_W'(1);
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
            src <= '0;
            dst <= '0;
            data <= '0;
            len <= '0;
            idx <= '0;
            aborted_o <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    src <= src_base_i;
                    dst <= dst_base_i;
                    len <= length_i;
                    idx <= '0;
                    aborted_o <= 1'b0;
                    state <= length_i == '0 ? DONE : READ;
                end
                READ: begin
                    data <= mem_data_i;
                    if (abort_i) aborted_o <= 1'b1;
                    state <= abort_i ? DONE : WRITE;
                end
                // the last word wins over a coincident abort, so a full copy never reports aborted
                WRITE: begin
                    idx <= idx + LEN_W'(1);
                    if (!last && abort_i) aborted_o <= 1'b1;
                    state <= (last || abort_i) ? DONE : READ;
                end
                DONE: state <= IDLE;
            endcase
        end
    end
    assign mem_address_o = state == READ ? src + 32'(idx) : state == WRITE ? dst + 32'(idx) : '0;
    assign mem_data_o = state == WRITE ? data : '0;
    assign mem_wren_o = state == WRITE;
    assign busy_o = state == READ || state == WRITE;
    assign done_o = state == DONE;
    assign count_o = idx;
endmodule

// File: tb/tb_image_copy_dma.sv
// tb_image_copy_dma: table-driven and randomized checks of image_copy_dma against a cycle-level copy model
module tb_image_copy_dma;
    localparam int LEN_W = 18;
    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic start_i = 1'b0;
    logic abort_i = 1'b0;
    logic [31:0] src_base_i = '0;
    logic [31:0] dst_base_i = '0;
    logic [LEN_W-1:0] length_i = '0;
    logic [31:0] mem_data_i, mem_address_o, mem_data_o;
    logic mem_wren_o, busy_o, done_o, aborted_o;
    logic [LEN_W-1:0] count_o;
    logic [31:0] mem [0:8191];
    logic [31:0] ref_mem [0:8191];
    int total = 0;
    int bad = 0;

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int len;
        int abort_at;
        int restart_at;
        bit abort_with_start;
        int exp_n;
        bit exp_ab;
    } vec_t;
    vec_t tbl [9];

    image_copy_dma #(.LEN_W(LEN_W)) dut (
        .CLK(CLK), .RST(RST), .start_i(start_i), .abort_i(abort_i),
        .src_base_i(src_base_i), .dst_base_i(dst_base_i), .length_i(length_i),
        .mem_data_i(mem_data_i), .mem_address_o(mem_address_o), .mem_data_o(mem_data_o),
        .mem_wren_o(mem_wren_o), .busy_o(busy_o), .done_o(done_o),
        .aborted_o(aborted_o), .count_o(count_o)
    );

    always #5 CLK = ~CLK;

    // sparse memory: region select plus the low 10 address bits, enough for every test window
    function automatic int unsigned mi(input logic [31:0] a);
        return {19'd0, a[18:16], a[9:0]};
    endfunction

    assign mem_data_i = mem[mi(mem_address_o)];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        if (mem_wren_o) mem[mi(mem_address_o)] = mem_data_o;
    endtask

    task automatic outcome(input int len, input int abort_at, output int n, output bit ab);
        if (len == 0 || abort_at == 0) begin
            n = len;
            ab = 1'b0;
        end else if (abort_at % 2 == 1) begin
            n = (abort_at - 1) / 2;
            ab = 1'b1;
        end else begin
            n = abort_at / 2;
            ab = n != len;
        end
    endtask

    task automatic run_copy(input string tag, input logic [31:0] src, input logic [31:0] dst,
                            input int len, input int abort_at, input int restart_at,
                            input bit aws, input int exp_n, input bit exp_ab);
        logic [31:0] exp_d [$];
        int done_c, diff;
        bit exp_wr;
        ref_mem = mem;
        for (int i = 0; i < exp_n; i++) begin
            exp_d.push_back(ref_mem[mi(src + 32'(i))]);
            ref_mem[mi(dst + 32'(i))] = exp_d[i];
        end
        done_c = abort_at > 0 ? abort_at + 1 : 2 * len + 1;
        src_base_i = src;
        dst_base_i = dst;
        length_i = LEN_W'(len);
        start_i = 1'b1;
        abort_i = aws;
        tick();
        start_i = 1'b0;
        abort_i = 1'b0;
        for (int c = 1; c <= done_c + 1; c++) begin
            exp_wr = c % 2 == 0 && c <= 2 * exp_n;
            check($sformatf("%s busy c%0d", tag, c), busy_o, c < done_c);
            check($sformatf("%s done c%0d", tag, c), done_o, c == done_c);
            check($sformatf("%s wren c%0d", tag, c), mem_wren_o, exp_wr);
            if (exp_wr) begin
                check($sformatf("%s waddr c%0d", tag, c), mem_address_o, dst + 32'(c / 2 - 1));
                check($sformatf("%s wdata c%0d", tag, c), mem_data_o, exp_d[c / 2 - 1]);
            end else if (c % 2 == 1 && c < done_c) begin
                check($sformatf("%s raddr c%0d", tag, c), mem_address_o, src + 32'((c - 1) / 2));
            end
            if (c == done_c) check($sformatf("%s aborted", tag), aborted_o, exp_ab);
            abort_i = c == abort_at;
            start_i = c == restart_at;
            if (c == restart_at) begin
                src_base_i = 32'h0005_0000;
                dst_base_i = 32'h0006_0000;
                length_i = LEN_W'(7);
            end
            tick();
        end
        start_i = 1'b0;
        abort_i = 1'b0;
        check($sformatf("%s count", tag), count_o, LEN_W'(exp_n));
        check($sformatf("%s aborted held", tag), aborted_o, exp_ab);
        diff = 0;
        for (int j = 0; j < 8192; j++) if (mem[j] !== ref_mem[j]) diff++;
        check($sformatf("%s memory image", tag), diff, 0);
    endtask

    initial begin
        int n, len, ab_at, rs_at;
        bit ab;
        logic [31:0] s, d;
        for (int j = 0; j < 8192; j++) mem[j] = $urandom;
        mem[mi(32'h1_0000)] = 32'h11;
        mem[mi(32'h1_0001)] = 32'h22;
        mem[mi(32'h1_0002)] = 32'h33;
        mem[mi(32'h1_0003)] = 32'h44;
        tbl[0] = '{32'h0001_0000, 32'h0004_0000, 4, 0, 0, 1'b0, 4, 1'b0};
        tbl[1] = '{32'h0001_0080, 32'h0004_0080, 0, 0, 0, 1'b0, 0, 1'b0};
        tbl[2] = '{32'h0001_0100, 32'h0004_0100, 3, 0, 3, 1'b0, 3, 1'b0};
        tbl[3] = '{32'h0001_0200, 32'h0004_0200, 5, 3, 0, 1'b0, 1, 1'b1};
        tbl[4] = '{32'h0001_FFFE, 32'h0004_0300, 4, 0, 0, 1'b0, 4, 1'b0};
        tbl[5] = '{32'h0003_0010, 32'h0003_0012, 5, 0, 0, 1'b0, 5, 1'b0};
        tbl[6] = '{32'h0001_0240, 32'h0004_0240, 5, 4, 0, 1'b0, 2, 1'b1};
        tbl[7] = '{32'h0001_0280, 32'h0004_0280, 3, 6, 0, 1'b0, 3, 1'b0};
        tbl[8] = '{32'h0001_02C0, 32'h0004_02C0, 2, 0, 0, 1'b1, 2, 1'b0};
        tick();
        tick();
        check("reset addr", mem_address_o, 32'h0);
        check("reset wdata", mem_data_o, 32'h0);
        check("reset wren", mem_wren_o, 1'b0);
        check("reset busy", busy_o, 1'b0);
        check("reset done", done_o, 1'b0);
        check("reset aborted", aborted_o, 1'b0);
        check("reset count", count_o, '0);
        RST = 1'b0;
        tick();
        for (int v = 0; v < 9; v++)
            run_copy($sformatf("vec%0d", v), tbl[v].src, tbl[v].dst, tbl[v].len, tbl[v].abort_at,
                     tbl[v].restart_at, tbl[v].abort_with_start, tbl[v].exp_n, tbl[v].exp_ab);
        check("basic dst0", mem[mi(32'h4_0000)], 32'h11);
        check("basic dst1", mem[mi(32'h4_0001)], 32'h22);
        check("basic dst2", mem[mi(32'h4_0002)], 32'h33);
        check("basic dst3", mem[mi(32'h4_0003)], 32'h44);
        // reset during the second write of a 4-word copy abandons it without a done pulse
        src_base_i = 32'h0001_0300;
        dst_base_i = 32'h0004_0380;
        length_i = LEN_W'(4);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int c = 1; c < 4; c++) tick();
        check("rst mid wren", mem_wren_o, 1'b1);
        check("rst mid count", count_o, LEN_W'(1));
        RST = 1'b1;
        tick();
        RST = 1'b0;
        check("rst after wren", mem_wren_o, 1'b0);
        check("rst after busy", busy_o, 1'b0);
        check("rst after count", count_o, '0);
        check("rst after done", done_o, 1'b0);
        for (int c = 0; c < 6; c++) begin
            check($sformatf("rst no done c%0d", c), done_o, 1'b0);
            tick();
        end
        run_copy("post rst", 32'h0001_0300, 32'h0004_0380, 4, 0, 0, 1'b0, 4, 1'b0);
        for (int r = 0; r < 20; r++) begin
            s = {13'd0, 3'($urandom_range(0, 7)), 16'($urandom_range(0, 900))};
            d = {13'd0, 3'($urandom_range(0, 7)), 16'($urandom_range(0, 900))};
            len = $urandom_range(0, 20);
            ab_at = (len == 0 || $urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 2 * len);
            rs_at = (ab_at == 0 && len > 1) ? $urandom_range(1, 2 * len - 1) : 0;
            outcome(len, ab_at, n, ab);
            run_copy($sformatf("rnd%0d", r), s, d, len, ab_at, rs_at, 1'($urandom_range(0, 1)), n, ab);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
